// File: rtl/washer_pkg.sv
// rtl/washer_pkg.sv - state codes and actuator masks for the washer sequencer
package washer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_FILL        = 4'd1,
    ST_WASH        = 4'd2,
    ST_DRAIN       = 4'd3,
    ST_RINSE_FILL  = 4'd4,
    ST_RINSE       = 4'd5,
    ST_RINSE_DRAIN = 4'd6,
    ST_SPIN        = 4'd7,
    ST_PAUSE       = 4'd8,
    ST_ABORT_DRAIN = 4'd9
  } state_e;

  // Actuator mask bit order: {agitator, motor, pump, speed, water}
  localparam logic [4:0] ACT_NONE    = 5'b00000;
  localparam logic [4:0] ACT_WATER   = 5'b00001;
  localparam logic [4:0] ACT_AGITATE = 5'b11000;
  localparam logic [4:0] ACT_PUMP    = 5'b00100;
  localparam logic [4:0] ACT_SPIN    = 5'b01110;

  function automatic logic [4:0] act_mask(input state_e s);
    logic [4:0] m;
    case (s)
      ST_FILL, ST_RINSE_FILL:                   m = ACT_WATER;
      ST_WASH, ST_RINSE:                        m = ACT_AGITATE;
      ST_DRAIN, ST_RINSE_DRAIN, ST_ABORT_DRAIN: m = ACT_PUMP;
      ST_SPIN:                                  m = ACT_SPIN;
      default:                                  m = ACT_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/washer_phase_timer.sv
// rtl/washer_phase_timer.sv - prescaled phase down-counter with load and hold
module washer_phase_timer #(
  parameter int TICK_DIV = 1000,
  parameter int TIMER_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_en,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               hold,
  output logic               expire
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               tick;

  assign tick   = (pre_q == PRE_LAST);
  // Expiry is reported regardless of hold so a held-at-expiry phase fires on resume.
  assign expire = tick && (cnt_q == '0);

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load_en) begin
      pre_d = '0;
      cnt_d = load_val;
    end else if (!hold) begin
      if (tick) begin
        pre_d = '0;
        cnt_d = cnt_q - 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/washer_sequencer.sv
// rtl/washer_sequencer.sv - washing-machine cycle FSM with pause, abort and rinse passes
module washer_sequencer
  import washer_pkg::*;
#(
  parameter int TICK_DIV  = 1000,
  parameter int TIMER_W   = 16,
  parameter int FILL_BASE = 20,
  parameter int WASH_BASE = 60,
  parameter int RINSE_T   = 30,
  parameter int DRAIN_T   = 15,
  parameter int SPIN_T    = 40,
  parameter int N_RINSE   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       door,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] load,
  output logic       agitator,
  output logic       motor,
  output logic       pump,
  output logic       speed,
  output logic       water,
  output logic       busy,
  output logic       done,
  output logic [3:0] phase,
  output logic [2:0] rinse_left
);

  state_e             state_q, state_d;
  state_e             saved_q, saved_d;
  logic [1:0]         load_q, load_d;
  logic [2:0]         rinse_q, rinse_d;
  logic               start_q, start_d;
  logic [4:0]         act_q, act_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_edge;
  logic               timer_load;
  logic               timer_hold;
  logic [TIMER_W-1:0] timer_val;
  logic               expire;

  function automatic logic [TIMER_W-1:0] phase_ticks(input state_e s, input logic [1:0] ld);
    int t;
    case (s)
      ST_FILL, ST_RINSE_FILL:                   t = FILL_BASE * (int'(ld) + 1);
      ST_WASH:                                  t = WASH_BASE * (int'(ld) + 1);
      ST_RINSE:                                 t = RINSE_T;
      ST_DRAIN, ST_RINSE_DRAIN, ST_ABORT_DRAIN: t = DRAIN_T;
      ST_SPIN:                                  t = SPIN_T;
      default:                                  t = 1;
    endcase
    return TIMER_W'(t - 1);
  endfunction

  assign start_edge = start && !start_q;

  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    load_d     = load_q;
    rinse_d    = rinse_q;
    start_d    = start;
    timer_load = 1'b0;
    timer_hold = (state_q == ST_IDLE) || (state_q == ST_PAUSE);

    case (state_q)
      ST_IDLE: begin
        if (start_edge && !door && !abort) begin
          state_d    = ST_FILL;
          load_d     = load;
          rinse_d    = 3'(N_RINSE);
          timer_load = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (abort) begin
          state_d    = ST_ABORT_DRAIN;
          timer_load = 1'b1;
        end else if (start_edge && !door) begin
          state_d = saved_q;
        end
      end
      ST_ABORT_DRAIN: begin
        if (expire) state_d = ST_IDLE;
      end
      default: begin
        if (abort) begin
          state_d    = ST_ABORT_DRAIN;
          timer_load = 1'b1;
        end else if (door) begin
          // A door opening on the expiry cycle must not consume it, or the counter would wrap.
          state_d    = ST_PAUSE;
          saved_d    = state_q;
          timer_hold = expire;
        end else if (expire) begin
          timer_load = 1'b1;
          case (state_q)
            ST_FILL:       state_d = ST_WASH;
            ST_WASH:       state_d = ST_DRAIN;
            ST_DRAIN:      state_d = (rinse_q != 3'd0) ? ST_RINSE_FILL : ST_SPIN;
            ST_RINSE_FILL: state_d = ST_RINSE;
            ST_RINSE:      state_d = ST_RINSE_DRAIN;
            ST_RINSE_DRAIN: begin
              rinse_d = rinse_q - 3'd1;
              state_d = (rinse_q != 3'd1) ? ST_RINSE_FILL : ST_SPIN;
            end
            default:       state_d = ST_IDLE;
          endcase
        end
      end
    endcase

    timer_val = phase_ticks(state_d, load_d);
    act_d     = act_mask(state_d);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_q == ST_SPIN) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      saved_q <= ST_IDLE;
      load_q  <= 2'd0;
      rinse_q <= 3'd0;
      start_q <= 1'b0;
      act_q   <= ACT_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      load_q  <= load_d;
      rinse_q <= rinse_d;
      start_q <= start_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  washer_phase_timer #(
    .TICK_DIV(TICK_DIV),
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_en (timer_load),
    .load_val(timer_val),
    .hold    (timer_hold),
    .expire  (expire)
  );

  assign {agitator, motor, pump, speed, water} = act_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign phase      = state_q;
  assign rinse_left = rinse_q;

endmodule

// File: tb/tb_washer_sequencer.sv
// tb/tb_washer_sequencer.sv - vector table, corner sequences and random run against a phase-plan model
module tb_washer_sequencer;

  localparam int TD = 2, FB = 3, WB = 4, RT = 2, DT = 2, ST = 3, NR = 1;
  localparam logic [4:0] M_Z = 5'b00000, M_W = 5'b00001, M_AM = 5'b11000, M_P = 5'b00100, M_S = 5'b01110;

  logic clk = 1'b0, reset_n = 1'b0, door = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0] load = 2'd0;
  logic agitator, motor, pump, speed, water, busy, done;
  logic [3:0] phase;
  logic [2:0] rinse_left;
  logic agitator0, motor0, pump0, speed0, water0, busy0, done0;
  logic [3:0] phase0;
  logic [2:0] rinse_left0;

  always #5 clk = ~clk;

  washer_sequencer #(.TICK_DIV(TD), .TIMER_W(8), .FILL_BASE(FB), .WASH_BASE(WB), .RINSE_T(RT),
                     .DRAIN_T(DT), .SPIN_T(ST), .N_RINSE(NR)) u_dut (
    .clk(clk), .reset_n(reset_n), .door(door), .start(start), .abort(abort), .load(load),
    .agitator(agitator), .motor(motor), .pump(pump), .speed(speed), .water(water),
    .busy(busy), .done(done), .phase(phase), .rinse_left(rinse_left));

  washer_sequencer #(.TICK_DIV(TD), .TIMER_W(8), .FILL_BASE(FB), .WASH_BASE(WB), .RINSE_T(RT),
                     .DRAIN_T(DT), .SPIN_T(ST), .N_RINSE(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .door(door), .start(start), .abort(abort), .load(load),
    .agitator(agitator0), .motor(motor0), .pump(pump0), .speed(speed0), .water(water0),
    .busy(busy0), .done(done0), .phase(phase0), .rinse_left(rinse_left0));

  typedef struct { int code; int clocks; } step_t;
  typedef struct { bit st; bit dr; bit ab; int ld; int n; int ph; logic [4:0] act; bit dn; int rin; } vec_t;

  step_t plan[$];
  vec_t  tbl[$];
  int    m_phase, m_rem, m_rinse;
  bit    m_paused, m_done, m_startq;
  int    n_vec, n_miss;

  function automatic logic [4:0] exp_mask(input int code);
    case (code)
      1, 4:    return M_W;
      2, 5:    return M_AM;
      3, 6, 9: return M_P;
      7:       return M_S;
      default: return M_Z;
    endcase
  endfunction

  function automatic logic [13:0] exp_pack(input int ph, input int rin, input bit dn, input logic [4:0] act);
    return {4'(ph), 3'(rin), (ph != 0), dn, act};
  endfunction

  function automatic logic [13:0] dut_pack();
    return {phase, rinse_left, busy, done, agitator, motor, pump, speed, water};
  endfunction

  function automatic logic [13:0] dut0_pack();
    return {phase0, rinse_left0, busy0, done0, agitator0, motor0, pump0, speed0, water0};
  endfunction

  function automatic logic [13:0] model_pack();
    int shown;
    shown = m_paused ? 8 : m_phase;
    return exp_pack(shown, m_rinse, m_done, exp_mask(shown));
  endfunction

  function automatic step_t mk_step(input int code, input int clocks);
    step_t s;
    s.code = code;
    s.clocks = clocks;
    return s;
  endfunction

  function automatic vec_t v(input bit st, input bit dr, input bit ab, input int ld, input int n,
                             input int ph, input logic [4:0] act, input bit dn, input int rin);
    vec_t r;
    r.st = st; r.dr = dr; r.ab = ab; r.ld = ld; r.n = n;
    r.ph = ph; r.act = act; r.dn = dn; r.rin = rin;
    return r;
  endfunction

  task automatic model_reset();
    plan.delete();
    m_phase = 0; m_rem = 0; m_rinse = 0;
    m_paused = 0; m_done = 0; m_startq = 0;
  endtask

  // Whole cycle laid out up front as {phase, clocks}; the head entry is the running phase.
  task automatic build_plan(input int l);
    plan.delete();
    plan.push_back(mk_step(1, FB * (l + 1) * TD));
    plan.push_back(mk_step(2, WB * (l + 1) * TD));
    plan.push_back(mk_step(3, DT * TD));
    for (int i = 0; i < NR; i++) begin
      plan.push_back(mk_step(4, FB * (l + 1) * TD));
      plan.push_back(mk_step(5, RT * TD));
      plan.push_back(mk_step(6, DT * TD));
    end
    plan.push_back(mk_step(7, ST * TD));
  endtask

  task automatic model_step();
    bit edge_s;
    edge_s   = start && !m_startq;
    m_startq = start;
    m_done   = 0;
    if (m_phase == 0) begin
      if (edge_s && !door && !abort) begin
        build_plan(int'(load));
        m_rinse = NR;
        m_phase = plan[0].code;
        m_rem   = plan[0].clocks;
      end
    end else if (m_phase == 9) begin
      if (m_rem == 1) m_phase = 0;
      else m_rem--;
    end else if (abort) begin
      plan.delete();
      m_paused = 0;
      m_phase  = 9;
      m_rem    = DT * TD;
    end else if (m_paused) begin
      if (edge_s && !door) m_paused = 0;
    end else if (door) begin
      m_paused = 1;
      if (m_rem > 1) m_rem--;
    end else if (m_rem == 1) begin
      if (plan[0].code == 6) m_rinse--;
      plan.delete(0);
      if (plan.size() == 0) begin
        m_phase = 0;
        m_done  = 1;
      end else begin
        m_phase = plan[0].code;
        m_rem   = plan[0].clocks;
      end
    end else begin
      m_rem--;
    end
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("cycle", dut_pack(), model_pack());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_miss %0d", n_miss);
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_miss = 0;
    model_reset();

    // normal cycle, load 0
    tbl.push_back(v(1,0,0,0,1, 1,M_W,0,1));  tbl.push_back(v(0,0,0,0,5, 1,M_W,0,1));
    tbl.push_back(v(0,0,0,0,1, 2,M_AM,0,1)); tbl.push_back(v(0,0,0,0,7, 2,M_AM,0,1));
    tbl.push_back(v(0,0,0,0,1, 3,M_P,0,1));  tbl.push_back(v(0,0,0,0,3, 3,M_P,0,1));
    tbl.push_back(v(0,0,0,0,1, 4,M_W,0,1));  tbl.push_back(v(0,0,0,0,5, 4,M_W,0,1));
    tbl.push_back(v(0,0,0,0,1, 5,M_AM,0,1)); tbl.push_back(v(0,0,0,0,3, 5,M_AM,0,1));
    tbl.push_back(v(0,0,0,0,1, 6,M_P,0,1));  tbl.push_back(v(0,0,0,0,3, 6,M_P,0,1));
    tbl.push_back(v(0,0,0,0,1, 7,M_S,0,0));  tbl.push_back(v(0,0,0,0,5, 7,M_S,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,M_Z,1,0));  tbl.push_back(v(0,0,0,0,1, 0,M_Z,0,0));
    // load 3 scaling, load change after latch, held abort
    tbl.push_back(v(1,0,0,3,1, 1,M_W,0,1));  tbl.push_back(v(0,0,0,0,23, 1,M_W,0,1));
    tbl.push_back(v(0,0,0,0,1, 2,M_AM,0,1)); tbl.push_back(v(0,0,0,0,31, 2,M_AM,0,1));
    tbl.push_back(v(0,0,0,0,1, 3,M_P,0,1));  tbl.push_back(v(0,0,1,0,1, 9,M_P,0,1));
    tbl.push_back(v(0,0,1,0,3, 9,M_P,0,1));  tbl.push_back(v(0,0,1,0,1, 0,M_Z,0,1));
    // door pause mid-WASH and resume
    tbl.push_back(v(1,0,0,0,1, 1,M_W,0,1));  tbl.push_back(v(0,0,0,0,5, 1,M_W,0,1));
    tbl.push_back(v(0,0,0,0,1, 2,M_AM,0,1)); tbl.push_back(v(0,0,0,0,3, 2,M_AM,0,1));
    tbl.push_back(v(0,1,0,0,1, 8,M_Z,0,1));  tbl.push_back(v(0,0,0,0,3, 8,M_Z,0,1));
    tbl.push_back(v(1,0,0,0,1, 2,M_AM,0,1)); tbl.push_back(v(0,0,0,0,3, 2,M_AM,0,1));
    tbl.push_back(v(0,0,0,0,1, 3,M_P,0,1));  tbl.push_back(v(0,0,1,0,1, 9,M_P,0,1));
    tbl.push_back(v(0,0,0,0,3, 9,M_P,0,1));  tbl.push_back(v(0,0,0,0,1, 0,M_Z,0,1));
    // abort during RINSE
    tbl.push_back(v(1,0,0,0,1, 1,M_W,0,1));  tbl.push_back(v(0,0,0,0,24, 5,M_AM,0,1));
    tbl.push_back(v(0,0,1,0,1, 9,M_P,0,1));  tbl.push_back(v(0,0,0,0,3, 9,M_P,0,1));
    tbl.push_back(v(0,0,0,0,1, 0,M_Z,0,1));
    // IDLE start filtering, abort+door on expiry, door on expiry, abort from PAUSE
    tbl.push_back(v(1,1,0,0,1, 0,M_Z,0,1));  tbl.push_back(v(1,0,0,0,1, 0,M_Z,0,1));
    tbl.push_back(v(0,0,0,0,1, 0,M_Z,0,1));  tbl.push_back(v(1,0,1,0,1, 0,M_Z,0,1));
    tbl.push_back(v(0,0,0,0,1, 0,M_Z,0,1));  tbl.push_back(v(1,0,0,0,1, 1,M_W,0,1));
    tbl.push_back(v(0,0,0,0,5, 1,M_W,0,1));  tbl.push_back(v(0,1,1,0,1, 9,M_P,0,1));
    tbl.push_back(v(0,0,0,0,3, 9,M_P,0,1));  tbl.push_back(v(0,0,0,0,1, 0,M_Z,0,1));
    tbl.push_back(v(1,0,0,0,1, 1,M_W,0,1));  tbl.push_back(v(0,0,0,0,5, 1,M_W,0,1));
    tbl.push_back(v(0,1,0,0,1, 8,M_Z,0,1));  tbl.push_back(v(0,0,0,0,1, 8,M_Z,0,1));
    tbl.push_back(v(1,1,0,0,1, 8,M_Z,0,1));  tbl.push_back(v(0,0,0,0,1, 8,M_Z,0,1));
    tbl.push_back(v(1,0,0,0,1, 1,M_W,0,1));  tbl.push_back(v(0,0,0,0,1, 2,M_AM,0,1));
    tbl.push_back(v(0,1,0,0,1, 8,M_Z,0,1));  tbl.push_back(v(0,0,1,0,1, 9,M_P,0,1));
    tbl.push_back(v(0,1,0,0,3, 9,M_P,0,1));  tbl.push_back(v(0,1,0,0,1, 0,M_Z,0,1));

    repeat (2) @(negedge clk);
    check("reset_state", dut_pack(), 14'd0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st;
      door  = tbl[i].dr;
      abort = tbl[i].ab;
      load  = 2'(tbl[i].ld);
      tick(tbl[i].n);
      check($sformatf("row%0d", i), dut_pack(), exp_pack(tbl[i].ph, tbl[i].rin, tbl[i].dn, tbl[i].act));
    end

    // asynchronous reset while spinning
    door = 1'b0; abort = 1'b0; load = 2'd0;
    start = 1'b1; tick(1);
    start = 1'b0; tick(32);
    check("reached_spin", 14'(phase), 14'd7);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", dut_pack(), 14'd0);
    check("async_reset_n0", dut0_pack(), 14'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // zero-rinse build skips straight from DRAIN to SPIN
    start = 1'b1; tick(1);
    start = 1'b0; tick(17);
    check("n0_drain", dut0_pack(), exp_pack(3, 0, 0, M_P));
    tick(1);
    check("n0_spin", dut0_pack(), exp_pack(7, 0, 0, M_S));
    tick(5);
    check("n0_spin_end", dut0_pack(), exp_pack(7, 0, 0, M_S));
    tick(1);
    check("n0_done", dut0_pack(), exp_pack(0, 0, 1, M_Z));

    for (int c = 0; c < 3000; c++) begin
      if (door) door = ($urandom_range(0, 3) != 0);
      else      door = ($urandom_range(0, 59) == 0);
      abort = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      load  = 2'($urandom_range(0, 3));
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
